regfile_scoreboard: RTL and testbench

//  Parametrised pipeline register file for the ID stage, replacing the fixed 2-read/1-write register stub.

---
 rtl/regfile_scoreboard_if.sv | 30 +++
 rtl/regfile_scoreboard.sv | 95 +++++++++
 tb/tb_regfile_scoreboard.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_scoreboard_if.sv
// ID/WB-facing bundle of the register file: read ports, issue marking and the WB write/retire port.
// master is the pipeline side that drives addresses and writes; slave is the register file.
interface regfile_scoreboard_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int NUM_RD = 2
);
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD-1:0]        rd_check;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic                     stall;
    logic                     issue_en;
    logic [ADDR_W-1:0]        issue_addr;
    logic                     issue_full;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic                     flush;

    modport master (
        output rd_addr, rd_check, issue_en, issue_addr, wr_en, wr_addr, wr_data, flush,
        input  rd_data, rd_busy, stall, issue_full
    );

    modport slave (
        input  rd_addr, rd_check, issue_en, issue_addr, wr_en, wr_addr, wr_data, flush,
        output rd_data, rd_busy, stall, issue_full
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// ID-stage register file with NUM_RD combinational read ports, one WB write port with optional
// forwarding, and a per-register pending-write counter that raises stall on RAW hazards.
module regfile_scoreboard #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 3,
    parameter int NUM_RD   = 2,
    parameter int CNT_W    = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    regfile_scoreboard_if.slave bus
);
    localparam int NUM_REGS = 1 << ADDR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [DATA_W-1:0]        regs [NUM_REGS];
    logic [CNT_W-1:0]         cnt  [NUM_REGS];
    logic                     issue_full_c;
    logic [NUM_RD*DATA_W-1:0] rd_data_c;
    logic [NUM_RD-1:0]        rd_busy_c;

    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // Saturation is handled by the callers: inc is gated by issue_full, dec by cnt != 0.
    function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cur,
                                                  input logic inc, input logic dec);
        case ({inc, dec})
            2'b10:   return cur + CNT_W'(1);
            2'b01:   return cur - CNT_W'(1);
            default: return cur;
        endcase
    endfunction

    assign issue_full_c = (cnt[bus.issue_addr] == CNT_MAX);

    always_comb begin
        logic [ADDR_W-1:0] a;
        logic              wr_hit;
        logic              dec_hit;
        rd_data_c = '0;
        rd_busy_c = '0;
        a         = '0;
        wr_hit    = 1'b0;
        dec_hit   = 1'b0;
        for (int i = 0; i < NUM_RD; i++) begin
            a       = bus.rd_addr[i*ADDR_W +: ADDR_W];
            wr_hit  = bus.wr_en && (bus.wr_addr == a);
            dec_hit = wr_hit && (cnt[a] != '0);
            if (!is_zero_reg(a)) begin
                if ((BYPASS != 0) && wr_hit)
                    rd_data_c[i*DATA_W +: DATA_W] = bus.wr_data;
                else
                    rd_data_c[i*DATA_W +: DATA_W] = regs[a];
                // With forwarding, the retiring write already satisfies this reader.
                if (BYPASS != 0)
                    rd_busy_c[i] = (cnt[a] - CNT_W'(dec_hit)) != '0;
                else
                    rd_busy_c[i] = (cnt[a] != '0);
            end
        end
    end

    assign bus.rd_data    = rd_data_c;
    assign bus.rd_busy    = rd_busy_c;
    assign bus.stall      = |(rd_busy_c & bus.rd_check);
    assign bus.issue_full = issue_full_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
        end else if (bus.wr_en && !is_zero_reg(bus.wr_addr)) begin
            regs[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Flush drops all outstanding marks; late retires of squashed work then see cnt == 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
        end else if (bus.flush) begin
            for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt[r] <= cnt_next(cnt[r],
                                   bus.issue_en && (bus.issue_addr == ADDR_W'(r)) &&
                                   !issue_full_c && !is_zero_reg(ADDR_W'(r)),
                                   bus.wr_en && (bus.wr_addr == ADDR_W'(r)) && (cnt[r] != '0));
            end
        end
    end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench for regfile_scoreboard with default parameters (BYPASS=1, ZERO_REG=1, CNT_W=2).
module tb_regfile_scoreboard;
    logic clk = 1'b0;
    logic rst_n;

    regfile_scoreboard_if #(.DATA_W(16), .ADDR_W(3), .NUM_RD(2)) bus ();

    regfile_scoreboard #(
        .DATA_W(16), .ADDR_W(3), .NUM_RD(2), .CNT_W(2), .ZERO_REG(1), .BYPASS(1)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        int          kind;
        logic [31:0] val;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad   = 0;
    logic [15:0] m_regs [8];
    int          m_cnt  [8];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // kinds: 0 rd_data0, 1 rd_data1, 2 rd_busy0, 3 rd_busy1, 4 stall, 5 issue_full
    function automatic logic [31:0] observe(input int kind);
        case (kind)
            0:       return 32'(bus.rd_data[15:0]);
            1:       return 32'(bus.rd_data[31:16]);
            2:       return 32'(bus.rd_busy[0]);
            3:       return 32'(bus.rd_busy[1]);
            4:       return 32'(bus.stall);
            default: return 32'(bus.issue_full);
        endcase
    endfunction

    task automatic push_exp(input string tag, input int kind, input logic [31:0] val);
        exp_t e;
        e.tag  = tag;
        e.kind = kind;
        e.val  = val;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk(e.tag, observe(e.kind), e.val);
        end
    endtask

    function automatic logic [15:0] m_rd(input logic [2:0] a);
        if (a == 3'd0) return 16'h0;
        if (bus.wr_en && bus.wr_addr == a) return bus.wr_data;
        return m_regs[a];
    endfunction

    function automatic logic m_busy(input logic [2:0] a);
        if (a == 3'd0) return 1'b0;
        if (bus.wr_en && bus.wr_addr == a && m_cnt[a] == 1) return 1'b0;
        return m_cnt[a] != 0;
    endfunction

    task automatic push_model();
        logic b0, b1;
        b0 = m_busy(bus.rd_addr[2:0]);
        b1 = m_busy(bus.rd_addr[5:3]);
        push_exp("m_rd0", 0, 32'(m_rd(bus.rd_addr[2:0])));
        push_exp("m_rd1", 1, 32'(m_rd(bus.rd_addr[5:3])));
        push_exp("m_busy0", 2, 32'(b0));
        push_exp("m_busy1", 3, 32'(b1));
        push_exp("m_stall", 4, 32'((b0 & bus.rd_check[0]) | (b1 & bus.rd_check[1])));
        push_exp("m_full", 5, 32'(m_cnt[bus.issue_addr] == 3));
    endtask

    task automatic model_reset();
        for (int r = 0; r < 8; r++) begin
            m_regs[r] = 16'h0;
            m_cnt[r]  = 0;
        end
    endtask

    task automatic model_update();
        logic full;
        logic inc, dec;
        full = (m_cnt[bus.issue_addr] == 3);
        for (int r = 0; r < 8; r++) begin
            if (bus.flush) begin
                m_cnt[r] = 0;
            end else begin
                inc = bus.issue_en && bus.issue_addr == 3'(r) && !full && r != 0;
                dec = bus.wr_en && bus.wr_addr == 3'(r) && m_cnt[r] != 0;
                if (inc && !dec) m_cnt[r] = m_cnt[r] + 1;
                if (dec && !inc) m_cnt[r] = m_cnt[r] - 1;
            end
        end
        if (bus.wr_en && bus.wr_addr != 3'd0) m_regs[bus.wr_addr] = bus.wr_data;
    endtask

    task automatic idle();
        bus.rd_addr    = '0;
        bus.rd_check   = '0;
        bus.issue_en   = 1'b0;
        bus.issue_addr = '0;
        bus.wr_en      = 1'b0;
        bus.wr_addr    = '0;
        bus.wr_data    = '0;
        bus.flush      = 1'b0;
    endtask

    // Inputs are set one unit after posedge; outputs are compared two units later.
    task automatic step();
        push_model();
        #2;
        drain();
        @(posedge clk);
        model_update();
        #1;
    endtask

    initial begin
        idle();
        model_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        for (int a = 0; a < 8; a++) begin
            bus.rd_addr  = {3'(7 - a), 3'(a)};
            bus.rd_check = 2'b11;
            #1;
            push_exp("rst_rd0", 0, 0);
            push_exp("rst_rd1", 1, 0);
            push_exp("rst_stall", 4, 0);
            push_model();
            drain();
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // WB write with same-cycle read of the same register
        idle(); bus.wr_en = 1'b1; bus.wr_addr = 3'd5; bus.wr_data = 16'hFFFD; bus.rd_addr = {3'd0, 3'd5};
        push_exp("byp_rd0", 0, 32'hFFFD); step();
        idle(); bus.rd_addr = {3'd5, 3'd5};
        push_exp("wr_rd1", 1, 32'hFFFD); step();

        // RAW hazard on reg 2
        idle(); bus.issue_en = 1'b1; bus.issue_addr = 3'd2; step();
        idle(); bus.rd_addr = {3'd0, 3'd2}; bus.rd_check = 2'b01;
        push_exp("raw_stall", 4, 1); step();
        bus.wr_en = 1'b1; bus.wr_addr = 3'd2; bus.wr_data = 16'h0222;
        push_exp("ret_stall", 4, 0); push_exp("ret_rd0", 0, 32'h0222); step();
        idle(); bus.rd_addr = {3'd0, 3'd2}; bus.rd_check = 2'b01;
        push_exp("post_stall", 4, 0); step();

        // Saturate reg 4
        idle(); bus.issue_en = 1'b1; bus.issue_addr = 3'd4;
        step(); step(); step();
        idle(); bus.issue_addr = 3'd4;
        push_exp("full3", 5, 1); step();
        bus.issue_en = 1'b1;
        push_exp("full_rej", 5, 1); step();
        idle(); bus.issue_addr = 3'd4;
        push_exp("full_hold", 5, 1); step();
        idle(); bus.wr_en = 1'b1; bus.wr_addr = 3'd4; bus.wr_data = 16'h0004; step();
        idle(); bus.issue_en = 1'b1; bus.issue_addr = 3'd4; bus.wr_en = 1'b1; bus.wr_addr = 3'd4;
        bus.wr_data = 16'h0044;
        push_exp("incdec_full", 5, 0); step();
        idle(); bus.issue_en = 1'b1; bus.issue_addr = 3'd4;
        push_exp("pre_full", 5, 0); step();
        idle(); bus.issue_addr = 3'd4; bus.rd_addr = {3'd0, 3'd4};
        push_exp("full_again", 5, 1); push_exp("busy4", 2, 1); step();
        for (int k = 0; k < 3; k++) begin
            idle(); bus.wr_en = 1'b1; bus.wr_addr = 3'd4; bus.wr_data = 16'(k + 16'h0400); step();
        end
        idle(); bus.rd_addr = {3'd0, 3'd4};
        push_exp("drained", 2, 0); push_exp("drain_rd", 0, 32'h0402); step();

        // Register 0 is hardwired
        idle(); bus.wr_en = 1'b1; bus.wr_addr = 3'd0; bus.wr_data = 16'hAAAA;
        push_exp("z_byp", 0, 0); step();
        idle(); push_exp("z_rd", 1, 0); step();
        idle(); bus.issue_en = 1'b1; bus.issue_addr = 3'd0; bus.rd_check = 2'b11;
        push_exp("z_full", 5, 0); step();
        idle(); bus.rd_check = 2'b11;
        push_exp("z_stall", 4, 0); push_exp("z_busy", 2, 0); step();

        // Flush clears all pending marks, including a same-cycle issue
        idle(); bus.issue_en = 1'b1; bus.issue_addr = 3'd1; step(); step();
        bus.issue_addr = 3'd6; step();
        idle(); bus.rd_addr = {3'd6, 3'd1}; bus.rd_check = 2'b11;
        push_exp("pre_flush", 4, 1); step();
        idle(); bus.flush = 1'b1; bus.issue_en = 1'b1; bus.issue_addr = 3'd6; step();
        idle(); bus.rd_addr = {3'd6, 3'd1}; bus.rd_check = 2'b11;
        push_exp("fl_stall", 4, 0); push_exp("fl_busy1", 3, 0); step();
        idle(); bus.wr_en = 1'b1; bus.wr_addr = 3'd1; bus.wr_data = 16'h0111; step();
        idle(); bus.rd_addr = {3'd6, 3'd1};
        push_exp("late_ret", 2, 0); push_exp("late_rd", 0, 32'h0111); step();

        // Asynchronous reset between edges
        idle(); bus.wr_en = 1'b1; bus.wr_addr = 3'd3; bus.wr_data = 16'h1234; step();
        idle(); bus.issue_en = 1'b1; bus.issue_addr = 3'd3; step();
        idle(); bus.rd_addr = {3'd0, 3'd3};
        push_exp("pre_rst_rd", 0, 32'h1234); push_exp("pre_rst_busy", 2, 1);
        #2 drain();
        rst_n = 1'b0;
        #1;
        push_exp("mid_rst_rd", 0, 0); push_exp("mid_rst_busy", 2, 0);
        model_reset();
        push_model();
        drain();
        rst_n = 1'b1;
        @(posedge clk);
        model_update();
        #1;

        // Random traffic against the model
        for (int n = 0; n < 200; n++) begin
            bus.rd_addr    = 6'($urandom);
            bus.rd_check   = 2'($urandom);
            bus.issue_en   = 1'($urandom);
            bus.issue_addr = 3'($urandom);
            bus.wr_en      = 1'($urandom);
            bus.wr_addr    = 3'($urandom);
            bus.wr_data    = 16'($urandom);
            bus.flush      = ($urandom_range(0, 15) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
